// File: rtl/crypto_instr_pkg.sv
// Crypto scalar opcode set shared by the issue arbiter and the crypto scalar FU.
package crypto_instr_pkg;

  typedef enum logic [3:0] {
    OP_ANDN   = 4'h0,
    OP_ORN    = 4'h1,
    OP_XNOR   = 4'h2,
    OP_PACK   = 4'h3,
    OP_PACKH  = 4'h4,
    OP_BREV8  = 4'h5,
    OP_REV8   = 4'h6,
    OP_ZIP    = 4'h7,
    OP_UNZIP  = 4'h8,
    OP_CLMUL  = 4'h9,
    OP_CLMULH = 4'hA,
    OP_XPERM4 = 4'hB,
    OP_XPERM8 = 4'hC,
    OP_IDLE   = 4'hF
  } opcode_t;

  // The FU does not decode this value, so it lands in its default (no result) branch.
  localparam opcode_t IdleOpcode = OP_IDLE;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crypto_res_fifo.sv
// Synchronous result FIFO with flush; Depth must be a power of two so the pointers
// wrap by plain overflow.
module crypto_res_fifo #(
  parameter type          entry_t = logic,
  parameter int unsigned  Depth   = 4,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  entry_t          data_i,
  input  logic            pop_i,
  output entry_t          data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  // A push into a full FIFO is only accepted alongside a pop of the head.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: storage is reset (unusual for a memory) so the head outputs read zero out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/crypto_fu_issue_arbiter.sv
// Round-robin issue arbiter in front of the single-cycle crypto scalar FU, with
// credit-based admission into a local result FIFO tagged by requester index.
module crypto_fu_issue_arbiter
  import crypto_instr_pkg::*;
#(
  parameter int unsigned  NrReq       = 2,
  parameter int unsigned  XLEN        = 64,
  parameter int unsigned  ResDepth    = 4,
  parameter type          hartid_t    = logic,
  parameter type          id_t        = logic,
  parameter type          registers_t = logic,
  localparam int unsigned SrcW        = idx_width(NrReq)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [NrReq-1:0] req_valid_i,
  output logic [NrReq-1:0] req_ready_o,
  input  opcode_t          req_opcode_i [NrReq],
  input  logic [31:0]      req_instr_i  [NrReq],
  input  logic [XLEN-1:0]  req_rs1_i    [NrReq],
  input  logic [XLEN-1:0]  req_rs2_i    [NrReq],
  input  hartid_t          req_hartid_i [NrReq],
  input  id_t              req_id_i     [NrReq],
  input  logic [4:0]       req_rd_i     [NrReq],
  output registers_t       fu_registers_o,
  output opcode_t          fu_opcode_o,
  output logic [31:0]      fu_instr_o,
  output hartid_t          fu_hartid_o,
  output id_t              fu_id_o,
  output logic [4:0]       fu_rd_o,
  input  logic [XLEN-1:0]  fu_result_i,
  input  hartid_t          fu_hartid_i,
  input  id_t              fu_id_i,
  input  logic [4:0]       fu_rd_i,
  input  logic             fu_valid_i,
  input  logic             fu_we_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [XLEN-1:0]  res_result_o,
  output hartid_t          res_hartid_o,
  output id_t              res_id_o,
  output logic [4:0]       res_rd_o,
  output logic             res_we_o,
  output logic [SrcW-1:0]  res_src_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(ResDepth) + 1;

  typedef struct packed {
    logic [XLEN-1:0] result;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
    logic [SrcW-1:0] src;
  } crypto_res_entry_t;

  logic [SrcW-1:0]   rr_q, rr_d, src_q, src_d, winner;
  logic              inflight_q, inflight_d;
  logic              found, credit_ok, grant, push, pop;
  logic [CntW-1:0]   count;
  logic              fifo_full, fifo_empty;
  crypto_res_entry_t push_entry, head_entry;

  // One credit per queued entry plus one for the op currently inside the FU.
  assign credit_ok = ({1'b0, count} + (CntW+1)'(inflight_q)) < (CntW+1)'(ResDepth);
  // Reset is folded in so the grant is held off for as long as rst_ni is low.
  assign grant     = found && credit_ok && !flush_i && rst_ni;

  // Two passes implement the wrap: first rr_q..NrReq-1, then 0..rr_q-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (!found && req_valid_i[i] && (SrcW'(i) >= rr_q)) begin
        found  = 1'b1;
        winner = SrcW'(i);
      end
    end
    for (int i = 0; i < NrReq; i++) begin
      if (!found && req_valid_i[i] && (SrcW'(i) < rr_q)) begin
        found  = 1'b1;
        winner = SrcW'(i);
      end
    end
  end

  always_comb begin
    req_ready_o    = '0;
    fu_registers_o = '0;
    fu_opcode_o    = IdleOpcode;
    fu_instr_o     = '0;
    fu_hartid_o    = '0;
    fu_id_o        = '0;
    fu_rd_o        = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
      fu_registers_o      = registers_t'({req_rs2_i[winner], req_rs1_i[winner]});
      fu_opcode_o         = req_opcode_i[winner];
      fu_instr_o          = req_instr_i[winner];
      fu_hartid_o         = req_hartid_i[winner];
      fu_id_o             = req_id_i[winner];
      fu_rd_o             = req_rd_i[winner];
    end
  end

  always_comb begin
    rr_d       = rr_q;
    src_d      = src_q;
    inflight_d = grant;
    if (grant) begin
      src_d = winner;
      rr_d  = (winner == SrcW'(NrReq - 1)) ? '0 : winner + SrcW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      src_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      src_q      <= src_d;
      inflight_q <= inflight_d;
    end
  end

  // A valid without a matching in-flight credit is a stray and is dropped.
  assign push       = fu_valid_i && inflight_q && !flush_i;
  assign pop        = res_valid_o && res_ready_i;
  assign push_entry = '{result: fu_result_i, hartid: fu_hartid_i, id: fu_id_i,
                        rd: fu_rd_i, we: fu_we_i, src: src_q};

  crypto_res_fifo #(
    .entry_t (crypto_res_entry_t),
    .Depth   (ResDepth)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(fifo_full && push && !pop));

  assign res_valid_o  = !fifo_empty;
  assign res_result_o = head_entry.result;
  assign res_hartid_o = head_entry.hartid;
  assign res_id_o     = head_entry.id;
  assign res_rd_o     = head_entry.rd;
  assign res_we_o     = head_entry.we;
  assign res_src_o    = head_entry.src;
  assign busy_o       = inflight_q || !fifo_empty;

endmodule

// File: tb/tb_crypto_fu_issue_arbiter.sv
// Bench for crypto_fu_issue_arbiter: vector table for arbitration/credit/flush,
// hand sequences for single issue, unsupported opcode and async reset.
module tb_crypto_fu_issue_arbiter;
  import crypto_instr_pkg::*;

  typedef logic [1:0]   hartid_t;
  typedef logic [3:0]   id_t;
  typedef logic [127:0] registers_t;

  typedef struct {
    logic [1:0] valid;
    logic       res_ready;
    logic       flush;
    logic [1:0] exp_ready;
    logic       exp_res_valid;
  } vec_t;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        src;
    hartid_t     hartid;
    id_t         id;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic [1:0]  req_valid, req_ready;
  opcode_t     req_opcode [2];
  logic [31:0] req_instr  [2];
  logic [63:0] req_rs1    [2];
  logic [63:0] req_rs2    [2];
  hartid_t     req_hartid [2];
  id_t         req_id     [2];
  logic [4:0]  req_rd     [2];
  registers_t  fu_regs;
  opcode_t     fu_opcode;
  logic [31:0] fu_instr;
  hartid_t     fu_hartid, fu_hartid_in;
  id_t         fu_id, fu_id_in;
  logic [4:0]  fu_rd, fu_rd_in;
  logic [63:0] fu_result;
  logic        fu_valid, fu_we;
  logic        res_valid, res_ready, res_we, res_src, busy;
  logic [63:0] res_result;
  hartid_t     res_hartid;
  id_t         res_id;
  logic [4:0]  res_rd;

  int   n_checks = 0;
  int   n_miscmp = 0;
  exp_t sb [$];
  vec_t vecs [$];

  always #5 clk_i = ~clk_i;

  crypto_fu_issue_arbiter #(
    .NrReq(2), .XLEN(64), .ResDepth(4),
    .hartid_t(hartid_t), .id_t(id_t), .registers_t(registers_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opcode_i(req_opcode), .req_instr_i(req_instr),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_hartid_i(req_hartid), .req_id_i(req_id), .req_rd_i(req_rd),
    .fu_registers_o(fu_regs), .fu_opcode_o(fu_opcode), .fu_instr_o(fu_instr),
    .fu_hartid_o(fu_hartid), .fu_id_o(fu_id), .fu_rd_o(fu_rd),
    .fu_result_i(fu_result), .fu_hartid_i(fu_hartid_in), .fu_id_i(fu_id_in),
    .fu_rd_i(fu_rd_in), .fu_valid_i(fu_valid), .fu_we_i(fu_we),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_result_o(res_result),
    .res_hartid_o(res_hartid), .res_id_o(res_id), .res_rd_o(res_rd),
    .res_we_o(res_we), .res_src_o(res_src), .busy_o(busy)
  );

  function automatic logic [63:0] fu_fn(input opcode_t o, input logic [63:0] a,
                                        input logic [63:0] b);
    if (o == OP_PACK) return {b[31:0], a[31:0]};
    return a ^ b;
  endfunction

  // Single-cycle FU: idle opcode (unsupported) yields no valid.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fu_valid <= 1'b0; fu_we <= 1'b0; fu_result <= '0;
      fu_rd_in <= '0; fu_hartid_in <= '0; fu_id_in <= '0;
    end else begin
      fu_valid     <= (fu_opcode != OP_IDLE);
      fu_we        <= 1'b1;
      fu_result    <= fu_fn(fu_opcode, fu_regs[63:0], fu_regs[127:64]);
      fu_rd_in     <= fu_rd;
      fu_hartid_in <= fu_hartid;
      fu_id_in     <= fu_id;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_fields(input int k);
    for (int r = 0; r < 2; r++) begin
      req_rs1[r]    = {32'(k), 32'(r)};
      req_rs2[r]    = {32'hA5A5_0000 | 32'(k), 32'hC3C3_0000 | 32'(r)};
      req_rd[r]     = 5'(2 * k + r + 1);
      req_opcode[r] = (k % 2 == 0) ? OP_PACK : OP_XNOR;
      req_hartid[r] = 2'(r);
      req_id[r]     = 4'(k);
      req_instr[r]  = 32'(k * 16 + r);
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic step(input logic [1:0] v, input logic rdy, input logic fl,
                      input logic [1:0] exp_rdy, input logic exp_rv);
    int   w;
    exp_t e;
    req_valid = v; res_ready = rdy; flush = fl;
    @(negedge clk_i);
    check("req_ready", req_ready, exp_rdy);
    check("res_valid", res_valid, exp_rv);
    if (exp_rdy != 2'b00) begin
      w = exp_rdy[1] ? 1 : 0;
      check("fu_opcode", fu_opcode, req_opcode[w]);
      check("fu_rd", fu_rd, req_rd[w]);
      check("fu_registers", fu_regs, {req_rs2[w], req_rs1[w]});
      if (req_opcode[w] != IdleOpcode)
        sb.push_back('{result: fu_fn(req_opcode[w], req_rs1[w], req_rs2[w]), rd: req_rd[w],
                       src: w[0], hartid: req_hartid[w], id: req_id[w]});
    end else begin
      check("fu_idle", {fu_opcode, fu_rd, fu_regs}, {IdleOpcode, 5'd0, 128'd0});
    end
    if (fl) begin
      sb.delete();
    end else if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_miscmp++;
        $display("FAIL sb_empty: got result rd=%0d required none", res_rd);
      end else begin
        e = sb.pop_front();
        check("res_result", res_result, e.result);
        check("res_rd", res_rd, e.rd);
        check("res_src", res_src, e.src);
        check("res_we", res_we, 1'b1);
        check("res_tags", {res_hartid, res_id}, {e.hartid, e.id});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_fu", {fu_opcode, fu_rd, fu_instr, fu_hartid, fu_id, fu_regs},
          {IdleOpcode, 5'd0, 32'd0, 2'd0, 4'd0, 128'd0});
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res", {res_result, res_rd, res_src, res_we}, '0);
    check("rst_busy", busy, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid = 2'b11; res_ready = 1'b0; flush = 1'b0;
    set_fields(0);
    #12;
    check_reset_state();
    req_valid = 2'b00;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single request, PACK with fixed operands; result visible two cycles later.
    req_opcode[0] = OP_PACK; req_rs1[0] = 64'h1234; req_rs2[0] = 64'hABCD; req_rd[0] = 5'd5;
    step(2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    check("t1_res_rd", res_rd, 5'd5);
    check("t1_res_result", res_result, 64'h0000ABCD_00001234);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // Unsupported opcode: no push, credit released, busy only while in flight.
    req_opcode[0] = IdleOpcode;
    step(2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    check("t4_busy_inflight", busy, 1'b1);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    check("t4_busy_idle", busy, 1'b0);
    check("t4_res_valid", res_valid, 1'b0);

    // Alternating grants at 1 op/cycle (rr_q starts at 1).
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b10, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b01, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b10, 1'b1});
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b01, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b0});
    // Consumer stalled: exactly four grants fill the FIFO, then resume after a pop.
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b10, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b01, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b10, 1'b1});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b01, 1'b1});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b10, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b0});
    // Flush one cycle after a grant with two entries queued (rr_q starts at 0).
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b01, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b10, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 1'b0, 2'b01, 1'b1});
    vecs.push_back('{2'b11, 1'b0, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b00, 1'b0});

    foreach (vecs[k]) begin
      set_fields(k + 10);
      step(vecs[k].valid, vecs[k].res_ready, vecs[k].flush,
           vecs[k].exp_ready, vecs[k].exp_res_valid);
    end
    check("t5_busy_after_flush", busy, 1'b0);

    // Three entries queued with rr_q=1, then asynchronous reset mid-cycle.
    set_fields(40);
    step(2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
    step(2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
    step(2'b01, 1'b0, 1'b0, 2'b01, 1'b1);
    step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    req_valid = 2'b11;
    #2 rst_ni = 1'b0;
    #1 check_reset_state();
    sb.delete();
    req_valid = 2'b00;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    set_fields(50);
    step(2'b11, 1'b1, 1'b0, 2'b01, 1'b0);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscmp);
    $finish;
  end

endmodule

// File: doc/crypto_fu_issue_arbiter.md
Name: crypto_fu_issue_arbiter

Overview:
Shares the single-cycle crypto scalar functional unit between NrReq issue requesters, for example per-hart CV-X-IF issue ports.
- Round-robin arbitration; at most one operation issued to the FU per cycle.
- A credit check guarantees every FU result has a slot in a local result FIFO.
- Results return through a valid/ready port tagged with the originating requester index.
- Sits between the issue stage(s) and crypto_scalar_fu, in front of the writeback path.

Parameters:
NrReq, 2, number of requesters (>=1).
XLEN, 64, datapath width; must match the FU.
ResDepth, 4, result FIFO entries (power of two, >=2).
hartid_t, logic, hart ID type, passed through.
id_t, logic, instruction ID type, passed through.
registers_t, logic, FU operand bundle type (two XLEN operands).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset (reset rst_ni, asynchronous, active-low; clock clk_i)
flush_i  in  1  discard queued and in-flight results; block grants this cycle
req_valid_i  in  NrReq  request valid per requester
req_ready_o  out  NrReq  one-hot grant (ready)
req_opcode_i  in  NrReq x opcode_t  crypto opcode
req_instr_i  in  NrReq x 32  raw instruction word
req_rs1_i / req_rs2_i  in  NrReq x XLEN  operands
req_hartid_i  in  NrReq x hartid_t  hart ID
req_id_i  in  NrReq x id_t  instruction ID
req_rd_i  in  NrReq x 5  destination register
fu_registers_o  out  registers_t  {rs2, rs1} of the granted request
fu_opcode_o  out  opcode_t  granted opcode, or IdleOpcode
fu_instr_o  out  32  granted instruction
fu_hartid_o / fu_id_o / fu_rd_o  out  -  granted tags
fu_result_i  in  XLEN  FU result (registered in FU)
fu_hartid_i / fu_id_i / fu_rd_i  in  -  FU returned tags
fu_valid_i / fu_we_i  in  1  FU valid / write enable
res_valid_o  out  1  FIFO head valid
res_ready_i  in  1  consumer accepts head
res_result_o  out  XLEN  head result
res_hartid_o / res_id_o / res_rd_o / res_we_o  out  -  head tags
res_src_o  out  $clog2(NrReq) (min 1)  requester index of head
busy_o  out  1  in-flight op or FIFO non-empty

Behaviour:
- Reset: req_ready_o=0, fu_opcode_o=IdleOpcode, all other fu_* outputs=0, res_valid_o=0, res_* outputs=0, busy_o=0, rr pointer=0, FIFO count=0, inflight_q=0.
- Credit: grant is allowed iff (count + inflight_q) < ResDepth and flush_i=0.
- Arbitration, combinational in-cycle:
  - Search starts at index rr_q and wraps modulo NrReq; the first requester with valid high wins.
  - req_ready_o is one-hot and is asserted only for the winner when a grant is allowed.
  - Handshake fires on valid & ready.
- On a grant:
  - fu_* outputs carry the winner's fields in the same cycle.
  - inflight_q<=1 and src_q<=winner at the next edge.
  - rr_q<=winner+1, wrapping to 0 at NrReq.
- With no grant: fu_opcode_o=IdleOpcode, fu_* fields=0, inflight_q<=0, rr_q unchanged.
- Latency: grant at cycle N; FU result at N+1; push at the N+1 edge; res_valid_o earliest at N+2, or the same cycle the FIFO goes non-empty. Back-to-back grants sustain 1 op/cycle while credit allows.
- Push: FIFO entry is {fu_result_i, fu tags, fu_we_i, src_q}, pushed when fu_valid_i & inflight_q & ~flush_i.
  - If inflight_q=1 but fu_valid_i=0 (unsupported opcode), nothing is pushed; the credit is still released.
  - fu_valid_i with inflight_q=0 is ignored.
- Pop: on res_valid_o & res_ready_i. Simultaneous push and pop leaves count unchanged and is legal when full.
- Full: credit blocks grants, so overflow is impossible.
- Empty: res_valid_o=0; res_* hold the last head value (don't-care).
- Pointer and count rules: FIFO pointers wrap modulo ResDepth; count is $clog2(ResDepth)+1 bits.
- flush_i:
  - The same cycle blocks grants.
  - The next edge sets count=0, read and write pointers equal, inflight_q=0.
  - Results arriving in the cycle after the flush cycle with inflight_q from a pre-flush grant are discarded.
  - rr_q is unchanged.
- Reset mid-operation: every register returns to its reset value immediately (async).

Decomposition:
- Shared package (crypto_instr_pkg): opcode_t (existing); new IdleOpcode constant (an opcode_t value that hits the FU default branch).
- Shared package: crypto_res_entry_t struct {result, hartid, id, rd, we, src}, parameterised via localparam widths in the module.
- Sub-module crypto_res_fifo: synchronous FIFO of crypto_res_entry_t with push, pop, flush, count, full and empty.
- The arbiter and credit logic stay in the top.

Test Plan:
1. Single request: req0 valid, PACK, rs1=0x1234, rs2=0xABCD, rd=5 at cycle 0 -> ready0=1 at cycle 0; FU model returns result at cycle 1; res_valid_o=1 at cycle 2 with rd=5, src=0, we=1.
2. Both requesters valid continuously, res_ready_i=1 -> grants alternate 0,1,0,1; one issue per cycle; results in grant order with res_src_o matching.
3. res_ready_i=0 with ResDepth=4 and continuous requests -> exactly 4 grants, then req_ready_o=0; count=4 with no loss. Raising res_ready_i resumes grants after the first pop.
4. Unsupported opcode granted, FU returns fu_valid_i=0 -> no FIFO push; credit restored next cycle; busy_o=0 at cycle 2.
5. flush_i asserted in the cycle after a grant while the FIFO holds 2 entries -> no grant that cycle; FIFO empty next cycle; the in-flight result is dropped; res_valid_o=0.
6. rst_ni deasserted (reset asserted) mid-stream with 3 entries queued -> all outputs return to reset values asynchronously; first grant after release goes to req0.
